calc_seq: RTL and testbench
===========================

# calc_seq

Parametrised, handshaked successor to the team's 4-bit calculator. It supports add, subtract, multiply and variable left-shift on WIDTH-bit operands and reports carry/overflow and zero flags. Multiply is an iterative shift-add that takes WIDTH cycles; the other modes complete in one cycle. The block sits between the operand registers and the result/display logic, and uses a start/busy/done handshake so callers can issue back-to-back operations.

## Interface
Parameters:
- WIDTH, default 4: operand and result width; must be ≥ 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on the accepted start.
- b  in  WIDTH  operand B, or the shift amount; captured on the accepted start.
- modo  in  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 SHL; captured on the accepted start.
- c  out  WIDTH  result; holds its value until the next result is written.
- rco  out  1  carry/borrow/overflow flag; holds with c.
- zero  out  1  1 when the written result c == 0; holds with c.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse when c/rco/zero are updated.

## Operation
Reset:
- rst=0 clears c, rco, zero, busy, done and all internal registers, and forces the FSM to IDLE.
- This applies immediately, mid-operation included.
- An aborted multiply produces no done and no result.

FSM states:
- IDLE:
  - start=1 and modo≠MUL: compute, write c/rco/zero, pulse done, stay in IDLE.
  - start=1 and modo=MUL: load multiplicand=a, multiplier=b, accumulator=0, count=WIDTH; go to MUL.
- MUL:
  - Each edge performs one iteration: add the multiplicand (shifted) when the multiplier LSB is 1, shift, and decrement count.
  - On the edge that completes iteration WIDTH: write the result, pulse done, return to IDLE.

Arithmetic (all results WIDTH bits):
- ADD: {rco,c} = a + b, computed at WIDTH+1 bits; rco is the carry out.
- SUB: {rco,c} = a − b, computed at WIDTH+1 bits; rco=1 means borrow (a < b); c wraps modulo 2^WIDTH.
- MUL: the full product P is 2·WIDTH bits. c = P[WIDTH-1:0]; rco = 1 iff P[2·WIDTH-1:WIDTH] ≠ 0.
- SHL: c = a << b, where the shift amount is the full b value.
  - rco = 1 iff any 1 bit was shifted out.
  - b = 0: c = a, rco = 0.
  - b ≥ WIDTH: c = 0, rco = |a.

Other rules:
- start while busy=1 is ignored; it is not queued.
- a, b and modo changing after capture have no effect on the operation in progress.

## Timing
- Start is accepted at edge k.
- ADD/SUB/SHL:
  - c/rco/zero are updated at edge k.
  - done=1 during the cycle after edge k; latency is 1.
  - busy stays 0, so start can be accepted on every cycle and gives one result per cycle.
- MUL:
  - busy=1 for exactly WIDTH cycles: from edge k through edge k+WIDTH.
  - The result and done=1 appear after edge k+WIDTH; busy=0 in that same cycle.
  - A start in the done cycle is accepted.
- done is never high for two consecutive cycles from a single operation.
- Back-to-back single-cycle ops may produce done=1 on consecutive cycles, one pulse per operation.
- c/rco/zero change only on the edge that produces done, or on reset.

## Structure
Package calc_pkg holds:
- the mode constants MODE_ADD/SUB/MUL/SHL (2 bits);
- the FSM state encoding ST_IDLE/ST_MUL.

Sub-module mul_shift_add holds the iterative multiplier datapath:
- inputs: load, step, a, b;
- outputs: product (2·WIDTH bits), last.

calc_seq holds:
- the FSM;
- the single-cycle ADD/SUB/SHL datapath;
- the flag/result registers.

Expected size is about 200 lines total.

## Test plan
All values are for WIDTH=4 unless noted.
- **ADD:** a=9, b=8 → c=1, rco=1, zero=0, done high only in the cycle after start. Then a=3, b=4 → c=7, rco=0.
- **SUB:** a=3, b=5 → c=4'hE, rco=1. Then a=5, b=5 → c=0, rco=0, zero=1.
- **MUL, WIDTH=4:**
  - a=7, b=3 → busy high 4 cycles, then c=5, rco=1, done one cycle.
  - a=3, b=5 → c=15, rco=0.
  - Any operand × 0 → c=0, rco=0, zero=1.
- **MUL, WIDTH=8:** a=200, b=2 → busy 8 cycles, c=8'h90, rco=1.
- **SHL:** a=4'b1011, b=2 → c=4'b1100, rco=1; b=0 → c=11, rco=0; b=5 → c=0, rco=1.
- **Robustness:**
  - start pulsed and a changed during MUL → both ignored; the original result is delivered.
  - rst driven low two cycles into MUL → c/rco/zero/busy/done go to 0 immediately, with no done.
  - After rst is released, ADD 2+2 gives c=4.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared mode and state encodings for calc_seq
package calc_pkg;

  // Operation select encoding on the modo input
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_SHL = 2'b11;

  // Controller states: single-cycle ops never leave IDLE
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// rtl/mul_shift_add.sv - iterative shift-add multiplier datapath, one bit per step
module mul_shift_add
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_next;

  // Accumulator value after the current iteration; exposed as product so the
  // controller can write the final result on the same edge as the last step
  always_comb begin
    acc_next = acc_q;
    if (mplier_q[0]) begin
      acc_next = acc_q + mcand_q;
    end
  end

  // Load operands on accept, otherwise advance one iteration per step
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH);
    end else if (step && (cnt_q != '0)) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  // Datapath registers, cleared by reset so an aborted multiply leaves nothing behind
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign product = acc_next;
  assign last    = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - handshaked add/sub/mul/shl calculator with carry and zero flags
module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       modo,
  output logic [WIDTH-1:0] c,
  output logic             rco,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t state_q, state_d;

  logic [WIDTH-1:0] c_q, c_d;
  logic             rco_q, rco_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic             mul_load;
  logic             mul_step;
  logic [2*WIDTH-1:0] mul_product;
  logic             mul_last;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [2*WIDTH-1:0] shl_w;
  logic [WIDTH-1:0]   alu_c;
  logic               alu_rco;

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load),
    .step   (mul_step),
    .a      (a),
    .b      (b),
    .product(mul_product),
    .last   (mul_last)
  );

  // Single-cycle datapath; SHL works at double width so shifted-out bits are visible
  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    diff_w  = {1'b0, a} - {1'b0, b};
    shl_w   = {{WIDTH{1'b0}}, a} << b;
    alu_c   = '0;
    alu_rco = 1'b0;
    case (modo)
      MODE_ADD: begin
        alu_c   = sum_w[WIDTH-1:0];
        alu_rco = sum_w[WIDTH];
      end
      MODE_SUB: begin
        alu_c   = diff_w[WIDTH-1:0];
        alu_rco = diff_w[WIDTH];
      end
      MODE_SHL: begin
        if (b >= WIDTH'(WIDTH)) begin
          alu_c   = '0;
          alu_rco = |a;
        end else begin
          alu_c   = shl_w[WIDTH-1:0];
          alu_rco = |shl_w[2*WIDTH-1:WIDTH];
        end
      end
      default: begin
        alu_c   = '0;
        alu_rco = 1'b0;
      end
    endcase
  end

  // Controller: next state, result write-back and done pulse
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    rco_d    = rco_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (modo == MODE_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            c_d    = alu_c;
            rco_d  = alu_rco;
            zero_d = (alu_c == '0);
            done_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          c_d     = mul_product[WIDTH-1:0];
          rco_d   = |mul_product[2*WIDTH-1:WIDTH];
          zero_d  = (mul_product[WIDTH-1:0] == '0);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any multiply without a done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      rco_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      rco_q   <= rco_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign c    = c_q;
  assign rco  = rco_q;
  assign zero = zero_q;
  assign done = done_q;
  assign busy = (state_q == ST_MUL);

endmodule

// File: tb/tb_calc_seq.sv
// tb/tb_calc_seq.sv - directed self-checking bench for calc_seq at WIDTH 4 and 8
module tb_calc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4;
  logic [3:0] a4, b4, c4;
  logic [1:0] modo4;
  logic       rco4, zero4, busy4, done4;

  logic       start8;
  logic [7:0] a8, b8, c8;
  logic [1:0] modo8;
  logic       rco8, zero8, busy8, done8;

  int checks = 0;
  int errors = 0;

  calc_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .modo(modo4),
    .c(c4), .rco(rco4), .zero(zero4), .busy(busy4), .done(done4)
  );

  calc_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .modo(modo8),
    .c(c8), .rco(rco8), .zero(zero8), .busy(busy8), .done(done8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
    start4 = 1'b1; a4 = a; b4 = b; modo4 = m;
    tick();
    start4 = 1'b0;
  endtask

  task automatic wait_done4(output int busy_cycles, output bit ok);
    busy_cycles = busy4 ? 1 : 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done4) begin
        ok = 1'b1;
        break;
      end
      if (busy4) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; modo4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0; modo8 = '0;
    tick(); tick();
    checks++;
    if ({c4, rco4, zero4, busy4, done4} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000000", {c4, rco4, zero4, busy4, done4});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_add();
    issue4(4'd9, 4'd8, 2'b00);
    checks++;
    if ({done4, c4, rco4, zero4} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_9_8: got done=%b c=%0d rco=%b zero=%b expected done=1 c=1 rco=1 zero=0", done4, c4, rco4, zero4);
    end
    tick();
    checks++;
    if (done4 !== 1'b0 || c4 !== 4'd1) begin
      errors++; $display("FAIL add_done_pulse: got done=%b c=%0d expected done=0 c=1", done4, c4);
    end
    issue4(4'd3, 4'd4, 2'b00);
    checks++;
    if ({done4, c4, rco4, zero4} !== {1'b1, 4'd7, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_3_4: got done=%b c=%0d rco=%b zero=%b expected done=1 c=7 rco=0 zero=0", done4, c4, rco4, zero4);
    end
    tick();
  endtask

  task automatic test_sub();
    issue4(4'd3, 4'd5, 2'b01);
    checks++;
    if ({c4, rco4, zero4} !== {4'hE, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_3_5: got c=%h rco=%b zero=%b expected c=e rco=1 zero=0", c4, rco4, zero4);
    end
    issue4(4'd5, 4'd5, 2'b01);
    checks++;
    if ({done4, c4, rco4, zero4} !== {1'b1, 4'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sub_5_5: got done=%b c=%0d rco=%b zero=%b expected done=1 c=0 rco=0 zero=1", done4, c4, rco4, zero4);
    end
    tick();
  endtask

  task automatic test_shl();
    issue4(4'b1011, 4'd2, 2'b11);
    checks++;
    if ({c4, rco4} !== {4'b1100, 1'b1}) begin
      errors++; $display("FAIL shl_b2: got c=%b rco=%b expected c=1100 rco=1", c4, rco4);
    end
    issue4(4'b1011, 4'd0, 2'b11);
    checks++;
    if ({c4, rco4} !== {4'd11, 1'b0}) begin
      errors++; $display("FAIL shl_b0: got c=%0d rco=%b expected c=11 rco=0", c4, rco4);
    end
    issue4(4'b1011, 4'd5, 2'b11);
    checks++;
    if ({c4, rco4, zero4} !== {4'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL shl_b5: got c=%0d rco=%b zero=%b expected c=0 rco=1 zero=1", c4, rco4, zero4);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_c [3] = '{4'd2, 4'd5, 4'd8};
    logic [3:0] va [3] = '{4'd1, 4'd7, 4'd1};
    logic [3:0] vb [3] = '{4'd1, 4'd2, 4'd3};
    logic [1:0] vm [3] = '{2'b00, 2'b01, 2'b11};
    start4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a4 = va[i]; b4 = vb[i]; modo4 = vm[i];
      tick();
      checks++;
      if (done4 !== 1'b1 || busy4 !== 1'b0 || c4 !== exp_c[i]) begin
        errors++; $display("FAIL b2b_%0d: got done=%b busy=%b c=%0d expected done=1 busy=0 c=%0d", i, done4, busy4, c4, exp_c[i]);
      end
    end
    start4 = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    int  bc;
    bit  ok;
    issue4(4'd7, 4'd3, 2'b10);
    checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0 || c4 !== 4'd8) begin
      errors++; $display("FAIL mul_accept: got busy=%b done=%b c=%0d expected busy=1 done=0 c=8", busy4, done4, c4);
    end
    wait_done4(bc, ok);
    checks++;
    if (!ok || bc != 4 || busy4 !== 1'b0 || c4 !== 4'd5 || rco4 !== 1'b1) begin
      errors++; $display("FAIL mul_7_3: got ok=%0d busy_cycles=%0d busy=%b c=%0d rco=%b expected ok=1 busy_cycles=4 busy=0 c=5 rco=1", ok, bc, busy4, c4, rco4);
    end
    tick();
    checks++;
    if (done4 !== 1'b0) begin
      errors++; $display("FAIL mul_done_pulse: got done=%b expected 0", done4);
    end
    issue4(4'd3, 4'd5, 2'b10);
    wait_done4(bc, ok);
    checks++;
    if (!ok || c4 !== 4'd15 || rco4 !== 1'b0 || zero4 !== 1'b0) begin
      errors++; $display("FAIL mul_3_5: got ok=%0d c=%0d rco=%b zero=%b expected ok=1 c=15 rco=0 zero=0", ok, c4, rco4, zero4);
    end
    tick();
    issue4(4'd9, 4'd0, 2'b10);
    wait_done4(bc, ok);
    checks++;
    if (!ok || c4 !== 4'd0 || rco4 !== 1'b0 || zero4 !== 1'b1) begin
      errors++; $display("FAIL mul_9_0: got ok=%0d c=%0d rco=%b zero=%b expected ok=1 c=0 rco=0 zero=1", ok, c4, rco4, zero4);
    end
    issue4(4'd2, 4'd3, 2'b00);
    checks++;
    if (done4 !== 1'b1 || c4 !== 4'd5) begin
      errors++; $display("FAIL start_in_done_cycle: got done=%b c=%0d expected done=1 c=5", done4, c4);
    end
    tick();
  endtask

  task automatic test_mul8();
    int bc;
    bit ok;
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd2; modo8 = 2'b10;
    tick();
    start8 = 1'b0;
    bc = busy8 ? 1 : 0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done8) begin
        ok = 1'b1;
        break;
      end
      if (busy8) bc++;
    end
    checks++;
    if (!ok || bc != 8 || c8 !== 8'h90 || rco8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++; $display("FAIL mul8_200_2: got ok=%0d busy_cycles=%0d c=%h rco=%b busy=%b expected ok=1 busy_cycles=8 c=90 rco=1 busy=0", ok, bc, c8, rco8, busy8);
    end
    tick();
  endtask

  task automatic test_robust();
    int  bc;
    bit  ok;
    bit  early_done;
    issue4(4'd7, 4'd3, 2'b10);
    bc = 1;
    ok = 1'b0;
    early_done = 1'b0;
    start4 = 1'b1; a4 = 4'd15; modo4 = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 1) start4 = 1'b0;
      if (done4) begin
        ok = 1'b1;
        break;
      end
      if (busy4) bc++;
    end
    start4 = 1'b0;
    checks++;
    if (!ok || bc != 4 || c4 !== 4'd5 || rco4 !== 1'b1) begin
      errors++; $display("FAIL mul_ignore_start: got ok=%0d busy_cycles=%0d c=%0d rco=%b expected ok=1 busy_cycles=4 c=5 rco=1", ok, bc, c4, rco4);
    end
    tick();
    issue4(4'd7, 4'd3, 2'b10);
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({c4, rco4, zero4, busy4, done4} !== 8'h00) begin
      errors++; $display("FAIL reset_mid_mul: got %b expected 00000000", {c4, rco4, zero4, busy4, done4});
    end
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4 || busy4) early_done = 1'b1;
    end
    checks++;
    if (early_done || c4 !== 4'd0) begin
      errors++; $display("FAIL abort_no_done: got spurious=%0d c=%0d expected spurious=0 c=0", early_done, c4);
    end
    issue4(4'd2, 4'd2, 2'b00);
    checks++;
    if (done4 !== 1'b1 || c4 !== 4'd4 || rco4 !== 1'b0) begin
      errors++; $display("FAIL add_after_reset: got done=%b c=%0d rco=%b expected done=1 c=4 rco=0", done4, c4, rco4);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shl();
    test_back_to_back();
    test_mul();
    test_mul8();
    test_robust();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
